// File: rtl/effect_mode_ctrl_if.sv
// Key/frame-sync inputs and committed effect outputs of the effect mode controller.
// The master side (key debouncer / sync source) drives inputs; the slave is the controller.
interface effect_mode_ctrl_if;
  logic              vs_in;
  logic              key_mode;
  logic              key_up;
  logic              key_down;
  logic              demo_en;
  logic [3:0]        state_current;
  logic signed [8:0] bright_adjust_val;
  logic [8:0]        contrast_adjust_val;
  logic signed [8:0] saturation_adjust_val;
  logic [7:0]        TH;
  logic              update_pending;

  modport master (
    output vs_in, key_mode, key_up, key_down, demo_en,
    input  state_current, bright_adjust_val, contrast_adjust_val,
           saturation_adjust_val, TH, update_pending
  );

  modport slave (
    input  vs_in, key_mode, key_up, key_down, demo_en,
    output state_current, bright_adjust_val, contrast_adjust_val,
           saturation_adjust_val, TH, update_pending
  );
endinterface

// File: rtl/effect_mode_ctrl.sv
// Effect selector sequencer: key pulses edit shadow mode/parameters, which are
// committed to the outputs only on the rising edge of vs_in (frame boundary).
module effect_mode_ctrl #(
  parameter int STEP_BRIGHT      = 8,
  parameter int STEP_CONTRAST    = 16,
  parameter int STEP_SAT         = 8,
  parameter int STEP_TH          = 4,
  parameter int CONTRAST_DEFAULT = 256,
  parameter int TH_DEFAULT       = 128,
  parameter int DEMO_FRAMES      = 120
) (
  input  logic clk,
  input  logic reset,
  effect_mode_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    M_BYPASS, M_BRIGHT, M_CONTRAST, M_SAT, M_RELIEF
  } mode_e;

  localparam int CNT_W = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;
  localparam logic [CNT_W-1:0] DEMO_LAST = CNT_W'(DEMO_FRAMES - 1);

  localparam logic signed [11:0] S_BRIGHT   = 12'(STEP_BRIGHT);
  localparam logic signed [11:0] S_CONTRAST = 12'(STEP_CONTRAST);
  localparam logic signed [11:0] S_SAT      = 12'(STEP_SAT);
  localparam logic signed [11:0] S_TH       = 12'(STEP_TH);
  localparam logic signed [11:0] D_CONTRAST = 12'(CONTRAST_DEFAULT);
  localparam logic signed [11:0] D_TH       = 12'(TH_DEFAULT);
  localparam logic [8:0]         CONTRAST_RST = 9'(CONTRAST_DEFAULT);
  localparam logic [7:0]         TH_RST       = 8'(TH_DEFAULT);

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      M_BYPASS:   return M_BRIGHT;
      M_BRIGHT:   return M_CONTRAST;
      M_CONTRAST: return M_SAT;
      M_SAT:      return M_RELIEF;
      default:    return M_BYPASS;
    endcase
  endfunction

  function automatic logic [3:0] mode_onehot(input mode_e m);
    case (m)
      M_BRIGHT:   return 4'b0001;
      M_CONTRAST: return 4'b0010;
      M_SAT:      return 4'b0100;
      M_RELIEF:   return 4'b1000;
      default:    return 4'b0000;
    endcase
  endfunction

  // Step in a 12-bit signed domain so overflow past either limit is visible, then clamp.
  function automatic logic signed [11:0] adjust(
    input logic signed [11:0] cur, step, dflt, lo, hi,
    input logic up, dn
  );
    logic signed [11:0] v;
    if (up && dn)  v = dflt;
    else if (up)   v = cur + step;
    else if (dn)   v = cur - step;
    else           v = cur;
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

  mode_e             mode_sh_q, mode_sh_d;
  logic signed [8:0] bright_sh_q, bright_sh_d, sat_sh_q, sat_sh_d;
  logic [8:0]        contrast_sh_q, contrast_sh_d;
  logic [7:0]        th_sh_q, th_sh_d;
  logic [3:0]        state_q, state_d;
  logic signed [8:0] bright_q, bright_d, sat_q, sat_d;
  logic [8:0]        contrast_q, contrast_d;
  logic [7:0]        th_q, th_d;
  logic [CNT_W-1:0]  demo_cnt_q, demo_cnt_d;
  logic              vs_q, vs_d;
  logic              pending_q, pending_d;

  logic               frame_start, mode_adv, keys_live, up, dn;
  logic signed [11:0] adj_bright, adj_contrast, adj_sat, adj_th;

  always_comb begin
    frame_start = bus.vs_in & ~vs_q;
    vs_d        = bus.vs_in;

    // Demo mode owns mode advancement; otherwise key_mode does and masks up/down.
    mode_adv  = bus.demo_en ? (frame_start && (demo_cnt_q == DEMO_LAST)) : bus.key_mode;
    keys_live = bus.demo_en || !bus.key_mode;
    up        = bus.key_up && keys_live;
    dn        = bus.key_down && keys_live;

    demo_cnt_d = demo_cnt_q;
    if (!bus.demo_en)
      demo_cnt_d = '0;
    else if (frame_start)
      demo_cnt_d = (demo_cnt_q == DEMO_LAST) ? '0 : demo_cnt_q + 1'b1;

    mode_sh_d = mode_adv ? next_mode(mode_sh_q) : mode_sh_q;

    adj_bright   = adjust($signed({{3{bright_sh_q[8]}}, bright_sh_q}), S_BRIGHT, 12'sd0,
                          -12'sd255, 12'sd255,
                          up && (mode_sh_q == M_BRIGHT), dn && (mode_sh_q == M_BRIGHT));
    adj_contrast = adjust($signed({3'b000, contrast_sh_q}), S_CONTRAST, D_CONTRAST,
                          12'sd0, 12'sd511,
                          up && (mode_sh_q == M_CONTRAST), dn && (mode_sh_q == M_CONTRAST));
    adj_sat      = adjust($signed({{3{sat_sh_q[8]}}, sat_sh_q}), S_SAT, 12'sd0,
                          -12'sd255, 12'sd255,
                          up && (mode_sh_q == M_SAT), dn && (mode_sh_q == M_SAT));
    adj_th       = adjust($signed({4'b0000, th_sh_q}), S_TH, D_TH,
                          12'sd0, 12'sd255,
                          up && (mode_sh_q == M_RELIEF), dn && (mode_sh_q == M_RELIEF));

    bright_sh_d   = 9'(adj_bright);
    contrast_sh_d = 9'(adj_contrast);
    sat_sh_d      = 9'(adj_sat);
    th_sh_d       = 8'(adj_th);

    // Commit uses post-update shadows so a same-cycle edit lands in this frame.
    state_d    = state_q;
    bright_d   = bright_q;
    contrast_d = contrast_q;
    sat_d      = sat_q;
    th_d       = th_q;
    if (frame_start) begin
      state_d    = mode_onehot(mode_sh_d);
      bright_d   = bright_sh_d;
      contrast_d = contrast_sh_d;
      sat_d      = sat_sh_d;
      th_d       = th_sh_d;
    end

    pending_d = (mode_onehot(mode_sh_d) != state_d) || (bright_sh_d != bright_d) ||
                (contrast_sh_d != contrast_d) || (sat_sh_d != sat_d) || (th_sh_d != th_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_sh_q     <= M_BYPASS;
      bright_sh_q   <= '0;
      contrast_sh_q <= CONTRAST_RST;
      sat_sh_q      <= '0;
      th_sh_q       <= TH_RST;
      state_q       <= 4'b0000;
      bright_q      <= '0;
      contrast_q    <= CONTRAST_RST;
      sat_q         <= '0;
      th_q          <= TH_RST;
      demo_cnt_q    <= '0;
      vs_q          <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      mode_sh_q     <= mode_sh_d;
      bright_sh_q   <= bright_sh_d;
      contrast_sh_q <= contrast_sh_d;
      sat_sh_q      <= sat_sh_d;
      th_sh_q       <= th_sh_d;
      state_q       <= state_d;
      bright_q      <= bright_d;
      contrast_q    <= contrast_d;
      sat_q         <= sat_d;
      th_q          <= th_d;
      demo_cnt_q    <= demo_cnt_d;
      vs_q          <= vs_d;
      pending_q     <= pending_d;
    end
  end

  assign bus.state_current         = state_q;
  assign bus.bright_adjust_val     = bright_q;
  assign bus.contrast_adjust_val   = contrast_q;
  assign bus.saturation_adjust_val = sat_q;
  assign bus.TH                    = th_q;
  assign bus.update_pending        = pending_q;

endmodule
